// File: rtl/burst_fifo_ctrl.sv
// burst_fifo_ctrl: first-word-fall-through circular FIFO staging DMA burst data
// for the accelerator datapath, with occupancy count, threshold flags,
// burst-granular availability flags, sticky error flags and synchronous flush.
module burst_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned BURST_LENGTH  = 128,
  parameter int          AFULL_THRESH  = int'(DEPTH) - 4,
  parameter int          AEMPTY_THRESH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    wen,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    ren,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    empty_flag,
  output logic                    full_flag,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    burst_avail,
  output logic                    space_avail,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Thresholds outside the count range collapse to constant-true/false flags.
  localparam bit              AF_NEVER  = (AFULL_THRESH > int'(DEPTH));
  localparam bit              AF_ALWAYS = (AFULL_THRESH <= 0);
  localparam logic [CW-1:0]   AF_TH     = (AF_NEVER || AF_ALWAYS) ? CW'(0) : CW'(AFULL_THRESH);
  localparam bit              AE_NEVER  = (AEMPTY_THRESH < 0);
  localparam bit              AE_ALWAYS = (AEMPTY_THRESH >= int'(DEPTH));
  localparam logic [CW-1:0]   AE_TH     = (AE_NEVER || AE_ALWAYS) ? CW'(0) : CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0]   BURST_CNT = CW'(BURST_LENGTH);
  localparam logic [CW-1:0]   SPACE_MAX = CW'(DEPTH - BURST_LENGTH);

  // Parameter legality checked at elaboration.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("burst_fifo_ctrl: DEPTH must be a power of two and >= 2");
  end
  if ((BURST_LENGTH < 1) || (BURST_LENGTH > DEPTH)) begin : g_bad_burst
    $error("burst_fifo_ctrl: BURST_LENGTH must be in 1..DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic wr_acc;
  logic rd_acc;

  // Status flags decoded from the registered occupancy.
  assign empty_flag   = (count_q == CW'(0));
  assign full_flag    = (count_q == FULL_CNT);
  assign almost_full  = !AF_NEVER && (AF_ALWAYS || (count_q >= AF_TH));
  assign almost_empty = !AE_NEVER && (AE_ALWAYS || (count_q <= AE_TH));
  assign burst_avail  = (count_q >= BURST_CNT);
  assign space_avail  = (count_q <= SPACE_MAX);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Head word is presented with zero latency.
  assign dout = mem_q[rptr_q[AW-1:0]];

  // A read on a full FIFO frees the slot for a simultaneous write.
  assign wr_acc = wen && (!full_flag || ren);
  assign rd_acc = ren && !empty_flag;

  // Next-state for pointers, occupancy and sticky errors.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    unf_d   = clr_err ? 1'b0 : unf_q;
    if (flush) begin
      wptr_d  = CW'(0);
      rptr_d  = CW'(0);
      count_d = CW'(0);
    end else begin
      if (wr_acc) wptr_d = wptr_q + CW'(1);
      if (rd_acc) rptr_d = rptr_q + CW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // A new error in the same cycle as clr_err takes priority.
      if (wen && !wr_acc) ovf_d = 1'b1;
      if (ren && !rd_acc) unf_d = 1'b1;
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (!flush && wr_acc) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: tb/tb_burst_fifo_ctrl.sv
// Directed self-checking bench for burst_fifo_ctrl (DEPTH=8, BURST_LENGTH=4).
module tb_burst_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        wen;
  logic [31:0] din;
  logic        ren;
  logic [31:0] dout;
  logic        empty_flag, full_flag, almost_empty, almost_full;
  logic [3:0]  count;
  logic        burst_avail, space_avail, overflow, underflow;
  logic        clr_err;

  int n_tests = 0;
  int n_fail  = 0;

  burst_fifo_ctrl #(
    .DATA_WIDTH(32), .DEPTH(8), .BURST_LENGTH(4), .AFULL_THRESH(6), .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wen(wen), .din(din), .ren(ren),
    .dout(dout), .empty_flag(empty_flag), .full_flag(full_flag),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .burst_avail(burst_avail), .space_avail(space_avail),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; ren = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if ({empty_flag, full_flag, almost_empty, almost_full} !== 4'b1010) begin
      n_fail++; $display("FAIL reset_flags got e/f/ae/af=%b exp 1010", {empty_flag, full_flag, almost_empty, almost_full}); end
    n_tests++; if ({burst_avail, space_avail, overflow, underflow} !== 4'b0100) begin
      n_fail++; $display("FAIL reset_burst_err got b/s/o/u=%b exp 0100", {burst_avail, space_avail, overflow, underflow}); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; din = 32'h10 + 32'(i);
      tick();
      n_tests++; if (count !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
      n_tests++; if (almost_empty !== (i < 2)) begin n_fail++; $display("FAIL fill_aempty[%0d] got %b exp %b", i, almost_empty, (i < 2)); end
      n_tests++; if (burst_avail !== (i >= 3)) begin n_fail++; $display("FAIL fill_burst[%0d] got %b exp %b", i, burst_avail, (i >= 3)); end
      n_tests++; if (space_avail !== (i < 4)) begin n_fail++; $display("FAIL fill_space[%0d] got %b exp %b", i, space_avail, (i < 4)); end
      n_tests++; if (almost_full !== (i >= 5)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b exp %b", i, almost_full, (i >= 5)); end
      n_tests++; if (full_flag !== (i == 7)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, full_flag, (i == 7)); end
    end
    wen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (dout !== 32'h10 + 32'(i)) begin n_fail++; $display("FAIL drain_dout[%0d] got %h exp %h", i, dout, 32'h10 + 32'(i)); end
      ren = 1'b1;
      tick();
    end
    ren = 1'b0;
    n_tests++; if (empty_flag !== 1'b1 || count !== 4'd0) begin
      n_fail++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", empty_flag, count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; din = 32'h100 + 32'(i);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      n_tests++; if (dout !== 32'h100 + 32'(k)) begin n_fail++; $display("FAIL b2b_dout[%0d] got %h exp %h", k, dout, 32'h100 + 32'(k)); end
      wen = 1'b1; ren = 1'b1; din = 32'h108 + 32'(k);
      tick();
      n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d exp 8", k, count); end
    end
    wen = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got %b exp 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (dout !== 32'h114 + 32'(i)) begin n_fail++; $display("FAIL b2b_tail[%0d] got %h exp %h", i, dout, 32'h114 + 32'(i)); end
      tick();
    end
    ren = 1'b0;
    n_tests++; if (empty_flag !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %b exp 1", empty_flag); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; din = 32'h200 + 32'(i);
      tick();
    end
    din = 32'hDEAD;
    tick();
    wen = 1'b0;
    n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d exp 8", count); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (dout !== 32'h200 + 32'(i)) begin n_fail++; $display("FAIL ovf_dout[%0d] got %h exp %h", i, dout, 32'h200 + 32'(i)); end
      ren = 1'b1;
      tick();
    end
    ren = 1'b0;
    n_tests++; if (empty_flag !== 1'b1 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_after_drain got empty=%b ovf=%b exp 1/1", empty_flag, overflow); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", overflow); end
  endtask

  task automatic test_underflow();
    wen = 1'b1; ren = 1'b1; din = 32'hA5;
    tick();
    idle();
    n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL unf_count got %0d exp 1", count); end
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b exp 1", underflow); end
    n_tests++; if (dout !== 32'hA5) begin n_fail++; $display("FAIL unf_dout got %h exp 000000a5", dout); end
    ren = 1'b1;
    tick();
    n_tests++; if (empty_flag !== 1'b1) begin n_fail++; $display("FAIL unf_pop_empty got %b exp 1", empty_flag); end
    clr_err = 1'b1; ren = 1'b1;
    tick();
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set_wins got %b exp 1", underflow); end
    ren = 1'b0;
    tick();
    clr_err = 1'b0;
    n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b exp 0", underflow); end
  endtask

  task automatic test_flush();
    ren = 1'b1;
    tick();
    ren = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wen = 1'b1; din = 32'h300 + 32'(i);
      tick();
    end
    n_tests++; if (count !== 4'd5 || burst_avail !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre got count=%0d burst=%b exp 5/1", count, burst_avail); end
    flush = 1'b1; wen = 1'b1; din = 32'h3FF;
    tick();
    idle();
    n_tests++; if (count !== 4'd0 || empty_flag !== 1'b1 || burst_avail !== 1'b0) begin
      n_fail++; $display("FAIL flush_state got count=%0d empty=%b burst=%b exp 0/1/0", count, empty_flag, burst_avail); end
    n_tests++; if (underflow !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL flush_err got unf=%b ovf=%b exp 1/0", underflow, overflow); end
    wen = 1'b1; din = 32'h77;
    tick();
    wen = 1'b0;
    n_tests++; if (dout !== 32'h77 || count !== 4'd1) begin
      n_fail++; $display("FAIL flush_rewrite got dout=%h count=%0d exp 00000077/1", dout, count); end
    ren = 1'b1; clr_err = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      wen = 1'b1; din = 32'h400 + 32'(i);
      tick();
    end
    wen = 1'b0;
    n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL arst_pre got %0d exp 3", count); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (count !== 4'd0 || empty_flag !== 1'b1) begin
      n_fail++; $display("FAIL arst_immediate got count=%0d empty=%b exp 0/1", count, empty_flag); end
    @(negedge clk);
    rst_n = 1'b1;
    wen = 1'b1; din = 32'hBEEF;
    tick();
    wen = 1'b0;
    n_tests++; if (dout !== 32'hBEEF || count !== 4'd1) begin
      n_fail++; $display("FAIL arst_rewrite got dout=%h count=%0d exp 0000beef/1", dout, count); end
    ren = 1'b1;
    tick();
    ren = 1'b0;
    n_tests++; if (empty_flag !== 1'b1) begin n_fail++; $display("FAIL arst_pop_empty got %b exp 1", empty_flag); end
  endtask

  initial begin
    rst_n = 1'b0;
    din   = '0;
    idle();
    #12 rst_n = 1'b1;
    tick();
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_overflow();
    test_underflow();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
